// File: rtl/issue_scheduler_pkg.sv
// Shared types and helper functions for the dual-issue scheduler.
// Decode slot layout, scheduler state encoding and hazard predicates.
package issue_scheduler_pkg;

  localparam int DEC_AW = 5;

  typedef struct packed {
    logic [DEC_AW-1:0] ARegAddrSrc0;
    logic [DEC_AW-1:0] ARegAddrSrc1;
    logic [DEC_AW-1:0] ARegAddrDst;
    logic              RegWrite;
    logic              MemRead;
    logic              MemWrite;
    logic [11:0]       Imm;
  } decode_struct;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PAIR   = 2'd1,
    B_ONLY = 2'd2
  } issue_state_e;

  // Register x0 is hardwired, so it never creates a dependency.
  function automatic logic reads_reg(decode_struct d, logic [DEC_AW-1:0] addr);
    return (addr != '0) && ((d.ARegAddrSrc0 == addr) || (d.ARegAddrSrc1 == addr));
  endfunction

  function automatic logic is_mem(decode_struct d);
    return d.MemRead || d.MemWrite;
  endfunction

  function automatic logic is_writer(decode_struct d);
    return d.RegWrite && (d.ARegAddrDst != '0);
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational pair hazard classifier: decides whether a held pair
// stalls for a load-use bubble, splits into two single issues, or
// dual-issues.
module issue_hazard_check
  import issue_scheduler_pkg::*;
(
  input  decode_struct      a,
  input  decode_struct      b,
  input  logic              lu_valid,
  input  logic [DEC_AW-1:0] lu_dst,
  output logic              bubble,
  output logic              split,
  output logic              dual
);

  logic raw;
  logic mem_conflict;
  logic waw;
  logic lu_b;
  logic unused_imm;

  assign unused_imm = ^{a.Imm, b.Imm};

  // Bubble outranks split, split outranks dual; exactly one is set.
  always_comb begin
    raw          = is_writer(a) && reads_reg(b, a.ARegAddrDst);
    mem_conflict = is_mem(a) && is_mem(b);
    waw          = is_writer(a) && is_writer(b) && (a.ARegAddrDst == b.ARegAddrDst);
    lu_b         = lu_valid && reads_reg(b, lu_dst);
    bubble       = lu_valid && reads_reg(a, lu_dst);
    split        = !bubble && (raw || mem_conflict || waw || lu_b);
    dual         = !bubble && !split;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler holding one decoded pair (A older than B).
// Optional macro ISSUE_PERF_CNT_EN adds saturating dual/single/bubble
// performance counters; scheduling is identical either way.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef ISSUE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  decode_struct i_decA,
  input  decode_struct i_decB,
  input  logic         i_stall,
  output logic         o_issueA_valid,
  output decode_struct o_issueA,
  output logic         o_issueB_valid,
  output decode_struct o_issueB
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_dual,
  output logic [CNT_W-1:0] o_cnt_single,
  output logic [CNT_W-1:0] o_cnt_bubble
`endif
);

  issue_state_e      state;
  decode_struct      held_a;
  decode_struct      held_b;
  logic              lu_valid;
  logic [REG_AW-1:0] lu_dst;

  logic hz_bubble;
  logic hz_split;
  logic hz_dual;
  logic b_bubble;
  logic drain;
  logic accept;
  logic load_a;
  logic load_b;

  issue_hazard_check u_hazard (
    .a        (held_a),
    .b        (held_b),
    .lu_valid (lu_valid),
    .lu_dst   (lu_dst),
    .bubble   (hz_bubble),
    .split    (hz_split),
    .dual     (hz_dual)
  );

  assign b_bubble = lu_valid && reads_reg(held_b, lu_dst);

  // Lane selection from held contents; a stall suppresses all issue.
  always_comb begin
    o_issueA_valid = 1'b0;
    o_issueA       = '0;
    o_issueB_valid = 1'b0;
    o_issueB       = '0;
    drain          = 1'b0;
    if (!i_stall) begin
      case (state)
        PAIR: begin
          if (hz_bubble) begin
            drain = 1'b0;
          end else if (hz_split) begin
            o_issueA_valid = 1'b1;
            o_issueA       = held_a;
          end else if (hz_dual) begin
            o_issueA_valid = 1'b1;
            o_issueA       = held_a;
            o_issueB_valid = 1'b1;
            o_issueB       = held_b;
            drain          = 1'b1;
          end
        end
        B_ONLY: begin
          if (!b_bubble) begin
            o_issueA_valid = 1'b1;
            o_issueA       = held_b;
            drain          = 1'b1;
          end
        end
        default: drain = 1'b0;
      endcase
    end
  end

  assign o_ready = (state == EMPTY) || drain;
  assign accept  = i_valid && o_ready;
  assign load_a  = o_issueA_valid && o_issueA.MemRead && (o_issueA.ARegAddrDst != '0);
  assign load_b  = o_issueB_valid && o_issueB.MemRead && (o_issueB.ARegAddrDst != '0);

  // State, held pair and load-use tracker; everything freezes under stall
  // except an accept into an empty scheduler.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= EMPTY;
      held_a   <= '0;
      held_b   <= '0;
      lu_valid <= 1'b0;
      lu_dst   <= '0;
    end else begin
      if (accept) begin
        state  <= PAIR;
        held_a <= i_decA;
        held_b <= i_decB;
      end else if (!i_stall) begin
        if (drain) begin
          state <= EMPTY;
        end else if ((state == PAIR) && hz_split) begin
          state <= B_ONLY;
        end
      end
      if (!i_stall) begin
        if (load_a) begin
          lu_valid <= 1'b1;
          lu_dst   <= o_issueA.ARegAddrDst;
        end else if (load_b) begin
          lu_valid <= 1'b1;
          lu_dst   <= o_issueB.ARegAddrDst;
        end else begin
          lu_valid <= 1'b0;
        end
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic ev_dual;
  logic ev_single;
  logic ev_bubble;

  assign ev_dual   = !i_stall && (state == PAIR) && hz_dual;
  assign ev_single = !i_stall && (((state == PAIR) && hz_split) || ((state == B_ONLY) && !b_bubble));
  assign ev_bubble = !i_stall && (((state == PAIR) && hz_bubble) || ((state == B_ONLY) && b_bubble));

  // Saturating per-cycle outcome counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_dual   <= '0;
      o_cnt_single <= '0;
      o_cnt_bubble <= '0;
    end else begin
      if (ev_dual && (o_cnt_dual != '1))     o_cnt_dual   <= o_cnt_dual + 1'b1;
      if (ev_single && (o_cnt_single != '1)) o_cnt_single <= o_cnt_single + 1'b1;
      if (ev_bubble && (o_cnt_bubble != '1)) o_cnt_bubble <= o_cnt_bubble + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: the stimulus thread queues expected
// issue events (with their cycle), a negedge monitor pops and compares.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_stall;
  decode_struct dec_a;
  decode_struct dec_b;
  logic         ready;
  logic         iss_a_valid;
  decode_struct iss_a;
  logic         iss_b_valid;
  decode_struct iss_b;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]  cnt_dual;
  logic [31:0]  cnt_single;
  logic [31:0]  cnt_bubble;
`endif

  issue_scheduler dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (i_valid),
    .o_ready        (ready),
    .i_decA         (dec_a),
    .i_decB         (dec_b),
    .i_stall        (i_stall),
    .o_issueA_valid (iss_a_valid),
    .o_issueA       (iss_a),
    .o_issueB_valid (iss_b_valid),
    .o_issueB       (iss_b)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .o_cnt_dual     (cnt_dual),
    .o_cnt_single   (cnt_single),
    .o_cnt_bubble   (cnt_bubble)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         av;
    decode_struct a;
    logic         bv;
    decode_struct b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h at cyc %0d", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic v, decode_struct a, decode_struct b, logic st, logic r);
    i_valid = v;
    dec_a   = a;
    dec_b   = b;
    i_stall = st;
    rst     = r;
  endtask

  task automatic expectIssue(int c, logic av, decode_struct a, logic bv, decode_struct b);
    exp_t e;
    e.cyc = c;
    e.av  = av;
    e.a   = a;
    e.bv  = bv;
    e.b   = b;
    sb.push_back(e);
  endtask

  function automatic decode_struct mk(int s0, int s1, int dst, bit rw, bit mr, bit mw, int imm);
    decode_struct d;
    d.ARegAddrSrc0 = 5'(s0);
    d.ARegAddrSrc1 = 5'(s1);
    d.ARegAddrDst  = 5'(dst);
    d.RegWrite     = rw;
    d.MemRead      = mr;
    d.MemWrite     = mw;
    d.Imm          = 12'(imm);
    return d;
  endfunction

  // Monitor: report overdue expectations, then compare any presented issue.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_issue expected at cyc %0d, still absent at cyc %0d", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (iss_a_valid || iss_b_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_issue at cyc %0d a=%0h b=%0h", cyc, iss_a, iss_b);
      end else begin
        e = sb.pop_front();
        checkOutput("issue_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("laneA_valid", 64'(iss_a_valid), 64'(e.av));
        checkOutput("laneA_data", 64'(iss_a), 64'(e.a));
        checkOutput("laneB_valid", 64'(iss_b_valid), 64'(e.bv));
        checkOutput("laneB_data", 64'(iss_b), 64'(e.b));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    decode_struct nop;
    decode_struct add1, addi4, add10, addi11, add12, addi13;
    decode_struct addi_x1, add_x2, lw_x1, sw_x3, lw_x5, addi_x6, add_x8, addi_x9;
    decode_struct add12b, lw_x7, add_x8b;

    nop     = '0;
    add1    = mk(2, 3, 1, 1, 0, 0, 0);
    addi4   = mk(5, 0, 4, 1, 0, 0, 7);
    add10   = mk(2, 3, 10, 1, 0, 0, 0);
    addi11  = mk(5, 0, 11, 1, 0, 0, 8);
    add12   = mk(6, 7, 12, 1, 0, 0, 0);
    addi13  = mk(8, 0, 13, 1, 0, 0, 9);
    addi_x1 = mk(0, 0, 1, 1, 0, 0, 5);
    add_x2  = mk(1, 1, 2, 1, 0, 0, 0);
    lw_x1   = mk(2, 0, 1, 1, 1, 0, 0);
    sw_x3   = mk(4, 3, 0, 0, 0, 1, 4);
    lw_x5   = mk(1, 0, 5, 1, 1, 0, 0);
    addi_x6 = mk(7, 0, 6, 1, 0, 0, 1);
    add_x8  = mk(5, 0, 8, 1, 0, 0, 0);
    addi_x9 = mk(0, 0, 9, 1, 0, 0, 2);
    add12b  = mk(9, 10, 14, 1, 0, 0, 0);
    lw_x7   = mk(3, 0, 7, 1, 1, 0, 0);
    add_x8b = mk(1, 0, 8, 1, 0, 0, 0);

    applyStimulus(0, nop, nop, 0, 1);
    step();
    step();
    checkOutput("reset_laneA_valid", 64'(iss_a_valid), 64'd0);
    checkOutput("reset_laneB_valid", 64'(iss_b_valid), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    applyStimulus(0, nop, nop, 0, 0);
    step();

    $display("[TB] test 1: back-to-back independent pairs");
    applyStimulus(1, add1, addi4, 0, 0);
    expectIssue(cyc + 1, 1, add1, 1, addi4);
    #1 checkOutput("t1_ready_0", 64'(ready), 64'd1);
    step();
    applyStimulus(1, add10, addi11, 0, 0);
    expectIssue(cyc + 1, 1, add10, 1, addi11);
    #1 checkOutput("t1_ready_1", 64'(ready), 64'd1);
    step();
    applyStimulus(1, add12, addi13, 0, 0);
    expectIssue(cyc + 1, 1, add12, 1, addi13);
    #1 checkOutput("t1_ready_2", 64'(ready), 64'd1);
    step();
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t1_ready_3", 64'(ready), 64'd1);
    step();
    step();

    $display("[TB] test 2: intra-pair RAW split");
    applyStimulus(1, addi_x1, add_x2, 0, 0);
    expectIssue(cyc + 1, 1, addi_x1, 0, nop);
    expectIssue(cyc + 2, 1, add_x2, 0, nop);
    step();
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t2_ready_split", 64'(ready), 64'd0);
    step();
    #1 checkOutput("t2_ready_bonly", 64'(ready), 64'd1);
    step();
    step();

    $display("[TB] test 3: memory port conflict split");
    applyStimulus(1, lw_x1, sw_x3, 0, 0);
    expectIssue(cyc + 1, 1, lw_x1, 0, nop);
    expectIssue(cyc + 2, 1, sw_x3, 0, nop);
    step();
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t3_ready_split", 64'(ready), 64'd0);
    step();
    step();
    step();

    $display("[TB] test 4: load-use bubble");
    applyStimulus(1, lw_x5, addi_x6, 0, 0);
    expectIssue(cyc + 1, 1, lw_x5, 1, addi_x6);
    step();
    applyStimulus(1, add_x8, addi_x9, 0, 0);
    expectIssue(cyc + 2, 1, add_x8, 1, addi_x9);
    #1 checkOutput("t4_ready_dual", 64'(ready), 64'd1);
    step();
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t4_bubble_ready", 64'(ready), 64'd0);
    checkOutput("t4_bubble_validA", 64'(iss_a_valid), 64'd0);
    checkOutput("t4_bubble_validB", 64'(iss_b_valid), 64'd0);
    step();
    #1 checkOutput("t4_after_ready", 64'(ready), 64'd1);
    step();
`ifdef ISSUE_PERF_CNT_EN
    checkOutput("t4_cnt_bubble", 64'(cnt_bubble), 64'd1);
    checkOutput("t4_cnt_single", 64'(cnt_single), 64'd4);
    checkOutput("t4_cnt_dual", 64'(cnt_dual), 64'd5);
`endif
    step();

    $display("[TB] test 5: accept under stall, hold, release");
    applyStimulus(1, add12b, nop, 1, 0);
    #1 checkOutput("t5_ready_empty_stall", 64'(ready), 64'd1);
    expectIssue(cyc + 4, 1, add12b, 1, nop);
    step();
    applyStimulus(0, nop, nop, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("t5_stall_ready", 64'(ready), 64'd0);
      checkOutput("t5_stall_validA", 64'(iss_a_valid), 64'd0);
      checkOutput("t5_stall_validB", 64'(iss_b_valid), 64'd0);
      step();
    end
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t5_release_ready", 64'(ready), 64'd1);
    step();
    step();

    $display("[TB] test 6: reset in B_ONLY clears tracker");
    applyStimulus(1, lw_x1, lw_x7, 0, 0);
    expectIssue(cyc + 1, 1, lw_x1, 0, nop);
    expectIssue(cyc + 2, 1, lw_x7, 0, nop);
    step();
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t6_ready_split", 64'(ready), 64'd0);
    step();
    applyStimulus(0, nop, nop, 0, 1);
    #1 checkOutput("t6_ready_bonly", 64'(ready), 64'd1);
    step();
    applyStimulus(1, add_x8b, addi_x9, 1, 0);
    #1 checkOutput("t6_post_reset_validA", 64'(iss_a_valid), 64'd0);
    checkOutput("t6_post_reset_validB", 64'(iss_b_valid), 64'd0);
    checkOutput("t6_post_reset_ready", 64'(ready), 64'd1);
    expectIssue(cyc + 1, 1, add_x8b, 1, addi_x9);
    step();
    applyStimulus(0, nop, nop, 0, 0);
    #1 checkOutput("t6_dual_ready", 64'(ready), 64'd1);
    step();
    step();
    step();

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
